cache_req_queue: RTL and testbench

- Request buffer directly upstream of the cache controller. Accepts load/store requests from the LSU and presents them to the controller in order, as cache_pkt fields, under a valid/ready handshake.
- Decouples LSU issue from controller stalls (miss, refill).
- Circular FIFO with first-word-fall-through output, occupancy count and synchronous flush.

---
 rtl/lib_pkg.sv | 21 ++
 rtl/cache_req_queue_stats.sv | 43 ++++
 rtl/cache_req_queue.sv | 106 ++++++++++
 tb/tb_cache_req_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lib_pkg.sv
// Shared cache packet definitions used by the request queue and the cache controller.
package lib;

  localparam int CACHE_AW = 30;
  localparam int CACHE_DW = 32;

  typedef struct packed {
    logic                valid;
    logic [CACHE_AW-1:0] addr;
    logic                we;
    logic [CACHE_DW-1:0] wdat;
  } cache_pkt;

  // Stored queue entry: cache_pkt without valid, which comes from the pointers.
  typedef struct packed {
    logic [CACHE_AW-1:0] addr;
    logic                we;
    logic [CACHE_DW-1:0] wdat;
  } cache_ent_t;

endpackage

// File: rtl/cache_req_queue_stats.sv
// Occupancy statistics for cache_req_queue; instantiated only under CACHE_REQ_STATS_EN.
module cache_req_stats #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stat_clr,
  input  logic          req_valid,
  input  logic          req_ready,
  input  logic [CW-1:0] count_next,
  output logic [31:0]   stat_full_cycles,
  output logic [CW-1:0] stat_hwm
);

  logic [31:0]   full_q, full_d;
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    full_d = full_q;
    hwm_d  = hwm_q;
    if (stat_clr) begin
      full_d = '0;
      hwm_d  = '0;
    end else begin
      if (req_valid && !req_ready && (full_q != 32'hFFFF_FFFF)) full_d = full_q + 32'd1;
      if (count_next > hwm_q) hwm_d = count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= '0;
      hwm_q  <= '0;
    end else begin
      full_q <= full_d;
      hwm_q  <= hwm_d;
    end
  end

  assign stat_full_cycles = full_q;
  assign stat_hwm         = hwm_q;

endmodule

// File: rtl/cache_req_queue.sv
// In-order LSU-to-cache-controller request FIFO, first-word-fall-through, with flush.
// Optional CACHE_REQ_STATS_EN adds stall-cycle and high-water-mark statistics.
module cache_req_queue
  import lib::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = CACHE_AW,
  parameter int DW    = CACHE_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_addr,
  input  logic                     req_we,
  input  logic [DW-1:0]            req_wdat,
  output logic                     cc_valid,
  input  logic                     cc_ready,
  output logic [AW-1:0]            cc_addr,
  output logic                     cc_we,
  output logic [DW-1:0]            cc_wdat,
`ifdef CACHE_REQ_STATS_EN
  input  logic                     stat_clr,
  output logic [31:0]              stat_full_cycles,
  output logic [$clog2(DEPTH):0]   stat_hwm,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  cache_ent_t    mem_q [DEPTH];
  cache_ent_t    wr_ent, head;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count_q, count_d;
  logic          enq, deq;

  // Flow control is a function of registered occupancy only.
  assign req_ready = (count_q != PW'(DEPTH));
  assign cc_valid  = (count_q != '0);
  assign enq       = req_valid & req_ready;
  assign deq       = cc_valid & cc_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + PW'(enq) - PW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    wr_ent      = '0;
    wr_ent.addr = req_addr;
    wr_ent.we   = req_we;
    wr_ent.wdat = req_wdat;
  end

  // Storage is not reset; a flushed enq never lands.
  always_ff @(posedge clk) begin
    if (enq && !flush) mem_q[wr_ptr_q[IW-1:0]] <= wr_ent;
  end

  assign head    = mem_q[rd_ptr_q[IW-1:0]];
  assign cc_addr = head.addr;
  assign cc_we   = head.we;
  assign cc_wdat = head.wdat;
  assign count   = count_q;

`ifdef CACHE_REQ_STATS_EN
  logic [PW-1:0] count_next;
  assign count_next = rst_n ? count_d : '0;

  cache_req_stats #(.CW(PW)) u_stats (
    .clk              (clk),
    .rst_n            (rst_n),
    .stat_clr         (stat_clr),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .count_next       (count_next),
    .stat_full_cycles (stat_full_cycles),
    .stat_hwm         (stat_hwm)
  );
`endif

endmodule

// File: tb/tb_cache_req_queue.sv
// Scoreboard bench for cache_req_queue: driver pushes expected entries, monitor pops on deq.
module tb_cache_req_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, flush, req_valid, req_ready, req_we, cc_valid, cc_ready, cc_we;
  logic [AW-1:0] req_addr, cc_addr;
  logic [DW-1:0] req_wdat, cc_wdat;
  logic [CW-1:0] count;
`ifdef CACHE_REQ_STATS_EN
  logic          stat_clr;
  logic [31:0]   stat_full_cycles;
  logic [CW-1:0] stat_hwm;
`endif

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cache_req_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_we           (req_we),
    .req_wdat         (req_wdat),
    .cc_valid         (cc_valid),
    .cc_ready         (cc_ready),
    .cc_addr          (cc_addr),
    .cc_we            (cc_we),
    .cc_wdat          (cc_wdat),
`ifdef CACHE_REQ_STATS_EN
    .stat_clr         (stat_clr),
    .stat_full_cycles (stat_full_cycles),
    .stat_hwm         (stat_hwm),
`endif
    .count            (count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every deq must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cc_valid === 1'b1 && cc_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got addr 0x%0h expected no output", cc_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cc_addr !== e.addr || cc_we !== e.we || (e.we && cc_wdat !== e.wdat)) begin
          n_fail++;
          $display("FAIL sb_data: got addr 0x%0h we %0b wdat 0x%0h expected addr 0x%0h we %0b wdat 0x%0h",
                   cc_addr, cc_we, cc_wdat, e.addr, e.we, e.wdat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; push the expectation once it will be accepted at the next edge.
  task automatic send(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d);
    bit done = 0;
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdat = d;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_t e;
        e.addr = a; e.we = we; e.wdat = d;
        exp_q.push_back(e);
        done = 1;
      end
      tick();
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
    req_wdat = '0; cc_ready = 1'b0;
`ifdef CACHE_REQ_STATS_EN
    stat_clr = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cc_valid", 32'(cc_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    tick();

    // Fill without drain.
    send(30'h10, 1'b1, 32'hA000_0010);
    send(30'h11, 1'b1, 32'hA000_0011);
    send(30'h12, 1'b0, 32'h0);
    send(30'h13, 1'b0, 32'h0);
    @(negedge clk);
    check("full_count", 32'(count), 32'd4);
    check("full_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b1; req_addr = 30'h14; req_we = 1'b1; req_wdat = 32'hDEAD_0014;
    tick(); tick();
    @(negedge clk);
    check("held_count", 32'(count), 32'd4);
    check("held_req_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 1'b0;

    // Drain: four consecutive deqs then empty.
    cc_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("drain_cc_valid", 32'(cc_valid), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    check("drain_sb_left", 32'(exp_q.size()), 32'd0);
    tick();

    // Simultaneous enq/deq at count=2 across pointer wrap.
    cc_ready = 1'b0;
    send(30'h20, 1'b1, 32'hB000_0020);
    send(30'h21, 1'b0, 32'h0);
    cc_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_addr = 30'h22 + 30'(i); req_we = i[0]; req_wdat = 32'hC000_0000 + 32'(i);
      @(negedge clk);
      check("ovl_count", 32'(count), 32'd2);
      if (req_ready) begin
        exp_t e;
        e.addr = req_addr; e.we = req_we; e.wdat = req_wdat;
        exp_q.push_back(e);
      end
      tick();
    end
    req_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("ovl_empty", 32'(count), 32'd0);
    check("ovl_sb_left", 32'(exp_q.size()), 32'd0);
    tick();

    // Flush at count=3 with a concurrent enq.
    cc_ready = 1'b0;
    send(30'h30, 1'b1, 32'hD000_0030);
    send(30'h31, 1'b1, 32'hD000_0031);
    send(30'h32, 1'b0, 32'h0);
    @(negedge clk);
    check("preflush_count", 32'(count), 32'd3);
    tick();
    req_valid = 1'b1; req_addr = 30'h3F; req_we = 1'b1; req_wdat = 32'hBAD0_003F;
    flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_count", 32'(count), 32'd0);
    check("flush_cc_valid", 32'(cc_valid), 32'd0);
    tick();
    cc_ready = 1'b1;
    send(30'h40, 1'b1, 32'hE000_0040);
    tick(); tick();
    @(negedge clk);
    check("postflush_sb_left", 32'(exp_q.size()), 32'd0);
    check("postflush_count", 32'(count), 32'd0);
    tick();

`ifdef CACHE_REQ_STATS_EN
    cc_ready = 1'b0;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    send(30'h50, 1'b1, 32'hF000_0050);
    send(30'h51, 1'b1, 32'hF000_0051);
    send(30'h52, 1'b0, 32'h0);
    send(30'h53, 1'b0, 32'h0);
    req_valid = 1'b1; req_addr = 30'h54; req_we = 1'b0; req_wdat = '0;
    repeat (7) tick();
    req_valid = 1'b0;
    @(negedge clk);
    check("stat_full_cycles", stat_full_cycles, 32'd7);
    check("stat_hwm", 32'(stat_hwm), 32'd4);
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    @(negedge clk);
    check("stat_clr_full", stat_full_cycles, 32'd0);
    check("stat_clr_hwm", 32'(stat_hwm), 32'd4 - 32'd4);
    tick();
    cc_ready = 1'b1;
    repeat (5) tick();
`endif

    @(negedge clk);
    check("final_sb_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
